qa_shim_c0_rd_arbiter: RTL and testbench
========================================

Name: qa_shim_c0_rd_arbiter

Overview:
- Shares the single channel 0 read-request path toward the QLP (or toward the simple TLB shim) between two AFU-side requesters.
- Arbitrates round-robin and tags each request with its client ID in the Mdata field.
- Bounds each client's outstanding reads with a credit counter.
- Routes channel 0 read responses back to the owning client by decoding the tag.

Parameters:
CCI_QLP_TX_HDR_WIDTH, 61, request header width
CCI_QLP_RX_HDR_WIDTH, 18, response header width
CCI_DATA_WIDTH, 512, response data width
CCI_TAG_WIDTH, 13, Mdata field width; bit CCI_TAG_WIDTH-1 is the client-ID bit owned by this block
MAX_OUTSTANDING, 64, per-client limit on in-flight reads; power of 2, minimum 2

Ports:
clk  in  1  clock
resetb  in  1  asynchronous active-low reset
req0_valid  in  1  client 0 read request present
req0_hdr  in  CCI_QLP_TX_HDR_WIDTH  client 0 request header
req0_deq  out  1  client 0 request accepted this cycle
req1_valid  in  1  client 1 read request present
req1_hdr  in  CCI_QLP_TX_HDR_WIDTH  client 1 request header
req1_deq  out  1  client 1 request accepted this cycle
qlp_c0_tx_alm_full  in  1  downstream almost full
qlp_c0_tx_rd_valid  out  1  read request to QLP
qlp_c0_tx_hdr  out  CCI_QLP_TX_HDR_WIDTH  tagged request header
qlp_c0_rx_rd_valid  in  1  read response valid
qlp_c0_rx_hdr  in  CCI_QLP_RX_HDR_WIDTH  response header
qlp_c0_rx_data  in  CCI_DATA_WIDTH  response data
rsp0_rd_valid  out  1  response to client 0
rsp1_rd_valid  out  1  response to client 1
rsp_hdr  out  CCI_QLP_RX_HDR_WIDTH  response header with client-ID bit cleared
rsp_data  out  CCI_DATA_WIDTH  response data
outstanding0  out  $clog2(MAX_OUTSTANDING)+1  client 0 in-flight count
outstanding1  out  $clog2(MAX_OUTSTANDING)+1  client 1 in-flight count
error  out  1  sticky protocol error

Behaviour:
Reset:
- resetb low asynchronously clears all registered outputs to 0, both counters to 0 and error to 0.
- The round-robin pointer last_grant resets to 1, so client 0 wins the first contest.
- Reset mid-operation discards all in-flight state. Responses to pre-reset requests arriving afterwards are treated as unexpected (see error).

Eligibility (combinational):
- eligN = reqN_valid && (outstandingN != MAX_OUTSTANDING) && !qlp_c0_tx_alm_full.

Arbitration (combinational):
- Only one eligible: it wins.
- Both eligible: the client != last_grant wins.
- reqN_deq is asserted for the winner only. At most one deq per cycle.
- Clients drop or advance their request on the cycle after deq.

Request pipeline:
- One register stage, so a request appears on qlp_c0_tx_* the cycle after deq (latency 1).
- qlp_c0_tx_hdr = winner header with bit CCI_TAG_WIDTH-1 replaced by the winner ID.
- qlp_c0_tx_rd_valid is deasserted in cycles with no grant.
- last_grant updates to the winner on each grant and holds when there is no grant.

Clients:
- Clients must drive bit CCI_TAG_WIDTH-1 of their Mdata as 0.
- Nonzero values are overwritten. The bit is always returned as 0.

Response routing:
- One register stage: qlp_c0_rx_rd_valid at cycle t gives rspN_rd_valid at t+1, where N = qlp_c0_rx_hdr[CCI_TAG_WIDTH-1].
- rsp_hdr equals the input header with that bit cleared. rsp_data is registered alongside.
- Both rsp valids are 0 when no response arrives.

Counters:
- outstandingN increments on reqN_deq and decrements on a response routed to N.
- Increment and decrement in the same cycle: the counter is unchanged.
- A counter never exceeds MAX_OUTSTANDING, which eligibility enforces. The counter blocks exactly at MAX_OUTSTANDING and resumes on the cycle after a decrement.

Error:
- Set when a response is routed to client N while outstandingN == 0. The counter saturates at 0 (no wrap).
- Cleared only by reset.

alm_full:
- Blocks new grants in the same cycle it is asserted.
- A request already registered is still issued.

Test Plan:
- Reset release, req0_valid=1 with req1 idle -> req0_deq=1 at cycle 0; qlp_c0_tx_rd_valid=1 at cycle 1 with hdr bit 12=0; outstanding0=1.
- Both clients valid for 6 cycles, alm_full=0 -> grants alternate 0,1,0,1,0,1; tx headers carry bit 12 = 0,1,0,1,0,1; each counter ends at 3.
- Client 1 alone issues 64 requests with no responses -> req1_deq stays 0 at outstanding1=64. One response with hdr bit 12=1 -> rsp1_rd_valid pulses 1 cycle later with bit 12 cleared; a grant resumes the following cycle; the counter returns to 64.
- A response to client 0 in the same cycle as a client 0 grant, with outstanding0=5 -> outstanding0 remains 5; rsp0_rd_valid=1 next cycle; rsp_data matches the input.
- alm_full=1 with both clients valid for 4 cycles -> no deq and no tx valid. After alm_full drops, the client != last_grant wins first.
- A response with bit 12=0 while outstanding0=0 -> error=1 and stays 1; outstanding0 stays 0. resetb pulse low mid-stream -> all outputs 0 immediately (asynchronously) and error cleared.

Source files
------------

// File: rtl/qa_shim_c0_rd_arbiter.sv
// Two-client round-robin arbiter for the channel 0 read-request path.
// It tags each request with the client ID, limits in-flight reads per client and routes responses back by tag.
module qa_shim_c0_rd_arbiter #(
  parameter int CCI_QLP_TX_HDR_WIDTH = 61,
  parameter int CCI_QLP_RX_HDR_WIDTH = 18,
  parameter int CCI_DATA_WIDTH       = 512,
  parameter int CCI_TAG_WIDTH        = 13,
  parameter int MAX_OUTSTANDING      = 64
) (
  input  logic                                 clk,
  input  logic                                 resetb,
  input  logic                                 req0_valid,
  input  logic [CCI_QLP_TX_HDR_WIDTH-1:0]      req0_hdr,
  output logic                                 req0_deq,
  input  logic                                 req1_valid,
  input  logic [CCI_QLP_TX_HDR_WIDTH-1:0]      req1_hdr,
  output logic                                 req1_deq,
  input  logic                                 qlp_c0_tx_alm_full,
  output logic                                 qlp_c0_tx_rd_valid,
  output logic [CCI_QLP_TX_HDR_WIDTH-1:0]      qlp_c0_tx_hdr,
  input  logic                                 qlp_c0_rx_rd_valid,
  input  logic [CCI_QLP_RX_HDR_WIDTH-1:0]      qlp_c0_rx_hdr,
  input  logic [CCI_DATA_WIDTH-1:0]            qlp_c0_rx_data,
  output logic                                 rsp0_rd_valid,
  output logic                                 rsp1_rd_valid,
  output logic [CCI_QLP_RX_HDR_WIDTH-1:0]      rsp_hdr,
  output logic [CCI_DATA_WIDTH-1:0]            rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding0,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding1,
  output logic                                 error
);

  localparam int CW     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int ID_BIT = CCI_TAG_WIDTH - 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic                            elig0, elig1, grant, winner;
  logic                            rx_tag, dec0, dec1, underflow;
  logic                            last_grant_q, last_grant_d;
  logic                            tx_valid_q, tx_valid_d;
  logic [CCI_QLP_TX_HDR_WIDTH-1:0] tx_hdr_q, tx_hdr_d;
  logic                            rsp0_valid_q, rsp0_valid_d;
  logic                            rsp1_valid_q, rsp1_valid_d;
  logic [CCI_QLP_RX_HDR_WIDTH-1:0] rsp_hdr_q, rsp_hdr_d;
  logic [CCI_DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic [CW-1:0]                   cnt0_q, cnt0_d;
  logic [CW-1:0]                   cnt1_q, cnt1_d;
  logic                            error_q, error_d;

  // last_grant_q holds the previous winner; on a tie the other client wins.
  always_comb begin
    elig0  = req0_valid && (cnt0_q != MAX_CNT) && !qlp_c0_tx_alm_full;
    elig1  = req1_valid && (cnt1_q != MAX_CNT) && !qlp_c0_tx_alm_full;
    grant  = elig0 || elig1;
    winner = (elig0 && elig1) ? ~last_grant_q : elig1;
    req0_deq = grant && !winner;
    req1_deq = grant && winner;
  end

  always_comb begin
    last_grant_d = grant ? winner : last_grant_q;
    tx_valid_d   = grant;
    tx_hdr_d     = tx_hdr_q;
    if (grant) begin
      tx_hdr_d         = winner ? req1_hdr : req0_hdr;
      tx_hdr_d[ID_BIT] = winner;
    end
  end

  always_comb begin
    rx_tag            = qlp_c0_rx_hdr[ID_BIT];
    rsp0_valid_d      = qlp_c0_rx_rd_valid && !rx_tag;
    rsp1_valid_d      = qlp_c0_rx_rd_valid && rx_tag;
    rsp_hdr_d         = qlp_c0_rx_hdr;
    rsp_hdr_d[ID_BIT] = 1'b0;
    rsp_data_d        = qlp_c0_rx_data;
  end

  // A response to a client with nothing in flight flags an error and is not counted down.
  always_comb begin
    dec0      = rsp0_valid_d && (cnt0_q != '0);
    dec1      = rsp1_valid_d && (cnt1_q != '0);
    underflow = (rsp0_valid_d && (cnt0_q == '0)) || (rsp1_valid_d && (cnt1_q == '0));
    error_d   = error_q || underflow;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    case ({req0_deq, dec0})
      2'b10:   cnt0_d = cnt0_q + ONE;
      2'b01:   cnt0_d = cnt0_q - ONE;
      default: cnt0_d = cnt0_q;
    endcase
    case ({req1_deq, dec1})
      2'b10:   cnt1_d = cnt1_q + ONE;
      2'b01:   cnt1_d = cnt1_q - ONE;
      default: cnt1_d = cnt1_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      last_grant_q <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_hdr_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_hdr_q    <= '0;
      rsp_data_q   <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      error_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      tx_valid_q   <= tx_valid_d;
      tx_hdr_q     <= tx_hdr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_hdr_q    <= rsp_hdr_d;
      rsp_data_q   <= rsp_data_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      error_q      <= error_d;
    end
  end

  assign qlp_c0_tx_rd_valid = tx_valid_q;
  assign qlp_c0_tx_hdr      = tx_hdr_q;
  assign rsp0_rd_valid      = rsp0_valid_q;
  assign rsp1_rd_valid      = rsp1_valid_q;
  assign rsp_hdr            = rsp_hdr_q;
  assign rsp_data           = rsp_data_q;
  assign outstanding0       = cnt0_q;
  assign outstanding1       = cnt1_q;
  assign error              = error_q;

endmodule

// File: tb/tb_qa_shim_c0_rd_arbiter.sv
// Testbench for qa_shim_c0_rd_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_qa_shim_c0_rd_arbiter;
  localparam int TXW  = 61;
  localparam int RXW  = 18;
  localparam int DW   = 512;
  localparam int TAGW = 13;
  localparam int MAXO = 64;
  localparam int CW   = 7;
  localparam int IDB  = TAGW - 1;

  logic clk = 1'b0;
  logic resetb;
  logic req0_valid, req1_valid, req0_deq, req1_deq;
  logic [TXW-1:0] req0_hdr, req1_hdr, qlp_c0_tx_hdr;
  logic qlp_c0_tx_alm_full, qlp_c0_tx_rd_valid, qlp_c0_rx_rd_valid;
  logic [RXW-1:0] qlp_c0_rx_hdr, rsp_hdr;
  logic [DW-1:0] qlp_c0_rx_data, rsp_data;
  logic rsp0_rd_valid, rsp1_rd_valid, error;
  logic [CW-1:0] outstanding0, outstanding1;

  always #5 clk = ~clk;

  qa_shim_c0_rd_arbiter #(
    .CCI_QLP_TX_HDR_WIDTH(TXW),
    .CCI_QLP_RX_HDR_WIDTH(RXW),
    .CCI_DATA_WIDTH(DW),
    .CCI_TAG_WIDTH(TAGW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .resetb(resetb),
    .req0_valid(req0_valid), .req0_hdr(req0_hdr), .req0_deq(req0_deq),
    .req1_valid(req1_valid), .req1_hdr(req1_hdr), .req1_deq(req1_deq),
    .qlp_c0_tx_alm_full(qlp_c0_tx_alm_full),
    .qlp_c0_tx_rd_valid(qlp_c0_tx_rd_valid), .qlp_c0_tx_hdr(qlp_c0_tx_hdr),
    .qlp_c0_rx_rd_valid(qlp_c0_rx_rd_valid), .qlp_c0_rx_hdr(qlp_c0_rx_hdr),
    .qlp_c0_rx_data(qlp_c0_rx_data),
    .rsp0_rd_valid(rsp0_rd_valid), .rsp1_rd_valid(rsp1_rd_valid),
    .rsp_hdr(rsp_hdr), .rsp_data(rsp_data),
    .outstanding0(outstanding0), .outstanding1(outstanding1),
    .error(error)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level reference: in-flight counts, last winner, and what should appear after the next edge.
  int             m_cnt [2];
  int             m_last;
  int             m_win;
  bit             m_err;
  bit             m_tx_valid;
  logic [TXW-1:0] m_tx_hdr;
  bit             m_rsp_v [2];
  logic [RXW-1:0] m_rsp_hdr;
  logic [DW-1:0]  m_rsp_data;
  logic           obs_deq0, obs_deq1;

  function automatic void model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_last = 1; m_win = -1; m_err = 0;
    m_tx_valid = 0; m_tx_hdr = '0;
    m_rsp_v[0] = 0; m_rsp_v[1] = 0;
    m_rsp_hdr = '0; m_rsp_data = '0;
  endfunction

  function automatic int model_winner();
    bit e0, e1;
    e0 = req0_valid && (m_cnt[0] < MAXO) && !qlp_c0_tx_alm_full;
    e1 = req1_valid && (m_cnt[1] < MAXO) && !qlp_c0_tx_alm_full;
    if (e0 && e1) return 1 - m_last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic void model_commit(int win);
    int tag;
    m_rsp_v[0] = 0; m_rsp_v[1] = 0;
    if (qlp_c0_rx_rd_valid) begin
      tag = int'(qlp_c0_rx_hdr[IDB]);
      m_rsp_v[tag] = 1;
      m_rsp_hdr = qlp_c0_rx_hdr;
      m_rsp_hdr[IDB] = 1'b0;
      m_rsp_data = qlp_c0_rx_data;
      if (m_cnt[tag] == 0) m_err = 1;
      else m_cnt[tag]--;
    end
    m_tx_valid = (win >= 0);
    if (win >= 0) begin
      m_tx_hdr = (win == 1) ? req1_hdr : req0_hdr;
      m_tx_hdr[IDB] = (win == 1);
      m_cnt[win]++;
      m_last = win;
    end
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [TXW-1:0] rand_txhdr();
    return TXW'({$urandom(), $urandom()});
  endfunction

  task automatic set_idle();
    req0_valid = 0; req1_valid = 0;
    qlp_c0_tx_alm_full = 0; qlp_c0_rx_rd_valid = 0;
  endtask

  // Inputs are already driven by the caller; sample deq, advance the model, then cross one edge.
  task automatic step();
    #1;
    obs_deq0 = req0_deq;
    obs_deq1 = req1_deq;
    m_win = model_winner();
    model_commit(m_win);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetb = 1;
  endtask

  task automatic test_reset();
    resetb = 0;
    set_idle();
    req0_hdr = '0; req1_hdr = '0; qlp_c0_rx_hdr = '0; qlp_c0_rx_data = '0;
    model_reset();
    #1;
    checks++; if (qlp_c0_tx_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %0b expected 0", qlp_c0_tx_rd_valid); end
    checks++; if ({rsp0_rd_valid, rsp1_rd_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_rd_valid, rsp1_rd_valid}); end
    checks++; if (outstanding0 !== '0 || outstanding1 !== '0) begin failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", outstanding0, outstanding1); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %0b expected 0", error); end
    checks++; if (qlp_c0_tx_hdr !== '0 || rsp_hdr !== '0 || rsp_data !== '0) begin failures++; $display("FAIL reset_data: tx_hdr %0h rsp_hdr %0h expected 0", qlp_c0_tx_hdr, rsp_hdr); end
    repeat (2) @(posedge clk);
    #1;
    resetb = 1;
  endtask

  task automatic test_single_grant();
    logic [TXW-1:0] h, exp_h;
    h = rand_txhdr();
    h[IDB] = 1'b1;
    exp_h = h;
    exp_h[IDB] = 1'b0;
    req0_hdr = h; req0_valid = 1;
    step();
    req0_valid = 0;
    checks++; if ({obs_deq0, obs_deq1} !== 2'b10) begin failures++; $display("FAIL single_deq: got %b expected 10", {obs_deq0, obs_deq1}); end
    checks++; if (qlp_c0_tx_rd_valid !== 1'b1) begin failures++; $display("FAIL single_tx_valid: got %0b expected 1", qlp_c0_tx_rd_valid); end
    checks++; if (qlp_c0_tx_hdr !== exp_h) begin failures++; $display("FAIL single_tx_hdr: got %0h expected %0h", qlp_c0_tx_hdr, exp_h); end
    checks++; if (outstanding0 !== CW'(1)) begin failures++; $display("FAIL single_count: got %0d expected 1", outstanding0); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req0_hdr = rand_txhdr(); req1_hdr = rand_txhdr();
      req0_valid = 1; req1_valid = 1;
      step();
      checks++; if ({obs_deq1, obs_deq0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_deq[%0d]: got deq1,deq0=%b expected client %0d", i, {obs_deq1, obs_deq0}, i % 2); end
      checks++; if (qlp_c0_tx_rd_valid !== 1'b1 || qlp_c0_tx_hdr[IDB] !== 1'((i % 2) == 1)) begin failures++; $display("FAIL rr_tag[%0d]: got valid %0b tag %0b expected 1/%0d", i, qlp_c0_tx_rd_valid, qlp_c0_tx_hdr[IDB], i % 2); end
      checks++; if (qlp_c0_tx_hdr !== m_tx_hdr) begin failures++; $display("FAIL rr_hdr[%0d]: got %0h expected %0h", i, qlp_c0_tx_hdr, m_tx_hdr); end
    end
    set_idle();
    checks++; if (outstanding0 !== CW'(3) || outstanding1 !== CW'(3)) begin failures++; $display("FAIL rr_counts: got %0d/%0d expected 3/3", outstanding0, outstanding1); end
  endtask

  task automatic test_full();
    logic [RXW-1:0] rh;
    logic [DW-1:0]  rd;
    int             ndeq;
    do_reset();
    ndeq = 0;
    req1_valid = 1;
    for (int i = 0; i < MAXO; i++) begin
      req1_hdr = rand_txhdr();
      step();
      if (obs_deq1 === 1'b1) ndeq++;
    end
    checks++; if (ndeq != MAXO) begin failures++; $display("FAIL full_fill: got %0d grants expected %0d", ndeq, MAXO); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (obs_deq1 !== 1'b0 || outstanding1 !== CW'(MAXO)) begin failures++; $display("FAIL full_block[%0d]: got deq %0b count %0d expected 0/%0d", i, obs_deq1, outstanding1, MAXO); end
    end
    rh = RXW'($urandom()); rh[IDB] = 1'b1;
    rd = rand_data();
    qlp_c0_rx_rd_valid = 1; qlp_c0_rx_hdr = rh; qlp_c0_rx_data = rd;
    step();
    qlp_c0_rx_rd_valid = 0;
    rh[IDB] = 1'b0;
    checks++; if (obs_deq1 !== 1'b0) begin failures++; $display("FAIL full_rsp_cycle_deq: got %0b expected 0", obs_deq1); end
    checks++; if ({rsp1_rd_valid, rsp0_rd_valid} !== 2'b10 || rsp_hdr !== rh) begin failures++; $display("FAIL full_rsp: got v1,v0=%b hdr %0h expected 10 hdr %0h", {rsp1_rd_valid, rsp0_rd_valid}, rsp_hdr, rh); end
    checks++; if (rsp_data !== rd) begin failures++; $display("FAIL full_rsp_data: got %0h expected %0h", rsp_data, rd); end
    checks++; if (outstanding1 !== CW'(MAXO - 1)) begin failures++; $display("FAIL full_dec: got %0d expected %0d", outstanding1, MAXO - 1); end
    step();
    checks++; if (obs_deq1 !== 1'b1) begin failures++; $display("FAIL full_resume: got %0b expected 1", obs_deq1); end
    checks++; if (outstanding1 !== CW'(MAXO) || rsp1_rd_valid !== 1'b0) begin failures++; $display("FAIL full_refill: got count %0d rsp1 %0b expected %0d/0", outstanding1, rsp1_rd_valid, MAXO); end
    set_idle();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] rd;
    do_reset();
    req0_valid = 1;
    repeat (5) begin req0_hdr = rand_txhdr(); step(); end
    checks++; if (outstanding0 !== CW'(5)) begin failures++; $display("FAIL same_pre: got %0d expected 5", outstanding0); end
    rd = rand_data();
    qlp_c0_rx_rd_valid = 1; qlp_c0_rx_hdr = RXW'($urandom()); qlp_c0_rx_hdr[IDB] = 1'b0; qlp_c0_rx_data = rd;
    step();
    set_idle();
    checks++; if (obs_deq0 !== 1'b1) begin failures++; $display("FAIL same_deq: got %0b expected 1", obs_deq0); end
    checks++; if (outstanding0 !== CW'(5)) begin failures++; $display("FAIL same_count: got %0d expected 5", outstanding0); end
    checks++; if (rsp0_rd_valid !== 1'b1 || rsp1_rd_valid !== 1'b0 || rsp_data !== rd) begin failures++; $display("FAIL same_rsp: got v0 %0b v1 %0b data %0h expected 1/0 %0h", rsp0_rd_valid, rsp1_rd_valid, rsp_data, rd); end
  endtask

  task automatic test_alm_full();
    do_reset();
    req0_valid = 1; req0_hdr = rand_txhdr();
    step();
    req1_valid = 1; req1_hdr = rand_txhdr();
    qlp_c0_tx_alm_full = 1;
    #1;
    checks++; if (qlp_c0_tx_rd_valid !== 1'b1) begin failures++; $display("FAIL af_registered_issue: got %0b expected 1", qlp_c0_tx_rd_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({obs_deq0, obs_deq1} !== 2'b00 || qlp_c0_tx_rd_valid !== 1'b0) begin failures++; $display("FAIL af_block[%0d]: got deq %b tx %0b expected 00/0", i, {obs_deq0, obs_deq1}, qlp_c0_tx_rd_valid); end
    end
    qlp_c0_tx_alm_full = 0;
    step();
    set_idle();
    checks++; if ({obs_deq1, obs_deq0} !== 2'b10) begin failures++; $display("FAIL af_resume_winner: got deq1,deq0=%b expected 10", {obs_deq1, obs_deq0}); end
  endtask

  task automatic test_error();
    do_reset();
    qlp_c0_rx_rd_valid = 1; qlp_c0_rx_hdr = '0; qlp_c0_rx_data = rand_data();
    step();
    qlp_c0_rx_rd_valid = 0;
    checks++; if (error !== 1'b1 || outstanding0 !== '0) begin failures++; $display("FAIL err_set: got err %0b count %0d expected 1/0", error, outstanding0); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_sticky[%0d]: got %0b expected 1", i, error); end
    end
    req0_valid = 1; req0_hdr = rand_txhdr();
    step();
    set_idle();
    checks++; if (qlp_c0_tx_rd_valid !== 1'b1 || outstanding0 !== CW'(1)) begin failures++; $display("FAIL err_pre_reset: got tx %0b count %0d expected 1/1", qlp_c0_tx_rd_valid, outstanding0); end
    #2;
    resetb = 0;
    #1;
    checks++; if (qlp_c0_tx_rd_valid !== 1'b0 || outstanding0 !== '0 || error !== 1'b0) begin failures++; $display("FAIL async_reset: got tx %0b count %0d err %0b expected 0/0/0", qlp_c0_tx_rd_valid, outstanding0, error); end
    model_reset();
    @(posedge clk);
    #1;
    resetb = 1;
  endtask

  task automatic test_random();
    int tag;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 9) < 7); req0_hdr = rand_txhdr();
      req1_valid = ($urandom_range(0, 9) < 7); req1_hdr = rand_txhdr();
      qlp_c0_tx_alm_full = ($urandom_range(0, 99) < 15);
      tag = int'($urandom_range(0, 1));
      qlp_c0_rx_rd_valid = (m_cnt[tag] > 0) && ($urandom_range(0, 1) == 1);
      qlp_c0_rx_hdr = RXW'($urandom()); qlp_c0_rx_hdr[IDB] = 1'(tag);
      qlp_c0_rx_data = rand_data();
      step();
      checks++; if (obs_deq0 !== (m_win == 0) || obs_deq1 !== (m_win == 1)) begin failures++; $display("FAIL rnd_deq[%0d]: got %b%b expected winner %0d", i, obs_deq1, obs_deq0, m_win); end
      checks++; if (qlp_c0_tx_rd_valid !== m_tx_valid || (m_tx_valid && qlp_c0_tx_hdr !== m_tx_hdr)) begin failures++; $display("FAIL rnd_tx[%0d]: got %0b %0h expected %0b %0h", i, qlp_c0_tx_rd_valid, qlp_c0_tx_hdr, m_tx_valid, m_tx_hdr); end
      checks++; if (rsp0_rd_valid !== m_rsp_v[0] || rsp1_rd_valid !== m_rsp_v[1]) begin failures++; $display("FAIL rnd_rsp_valid[%0d]: got %b%b expected %b%b", i, rsp1_rd_valid, rsp0_rd_valid, m_rsp_v[1], m_rsp_v[0]); end
      if (m_rsp_v[0] || m_rsp_v[1]) begin
        checks++; if (rsp_hdr !== m_rsp_hdr || rsp_data !== m_rsp_data) begin failures++; $display("FAIL rnd_rsp_payload[%0d]: got hdr %0h expected %0h", i, rsp_hdr, m_rsp_hdr); end
      end
      checks++; if (int'(outstanding0) != m_cnt[0] || int'(outstanding1) != m_cnt[1]) begin failures++; $display("FAIL rnd_counts[%0d]: got %0d/%0d expected %0d/%0d", i, outstanding0, outstanding1, m_cnt[0], m_cnt[1]); end
      checks++; if (error !== m_err) begin failures++; $display("FAIL rnd_error[%0d]: got %0b expected %0b", i, error, m_err); end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_full();
    test_same_cycle();
    test_alm_full();
    test_error();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
